// File: rtl/uart_rx_deserializer.sv
// UART receiver: 16x oversampled, 3-sample majority vote, 8N1 framing.
// Define UART_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_deserializer #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [2:0] {
        RECOVER,
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_PARITY_EN
        ,
        PARITY
`endif
    } state_e;

    state_e        state_q, state_d;
    logic          rx_meta_q, rxs_q;
    logic [1:0]    sync_vld_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          s7_q, s7_d, s8_q, s8_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_status_q, rx_status_d;
    logic          frame_err_q, frame_err_d;
`ifdef UART_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          parity_err_q, parity_err_d;
`endif

    logic rxs, tick, mid, last, maj;

    // sync_vld_q keeps RECOVER from trusting the reset value of the synchronizer
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            sync_vld_q <= 2'b00;
        end else begin
            rx_meta_q  <= uart_rx;
            rxs_q      <= rx_meta_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    assign rxs  = rxs_q;
    assign tick = (div_cnt_q == DIV_MAX);
    assign mid  = tick && (tcnt_q == 4'd9);
    assign last = tick && (tcnt_q == 4'd15);
    assign maj  = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        tcnt_d      = tick ? tcnt_q + 4'd1 : tcnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        s7_d        = (tick && tcnt_q == 4'd7) ? rxs : s7_q;
        s8_d        = (tick && tcnt_q == 4'd8) ? rxs : s8_q;
        rx_data_d   = rx_data_q;
        rx_status_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            RECOVER: begin
                tcnt_d = '0;
                if (sync_vld_q[1] && rxs) state_d = IDLE;
            end
            IDLE: begin
                tcnt_d = '0;
                if (!rxs) begin
                    state_d   = START;
                    div_cnt_d = '0;
                end
            end
            START: begin
                bit_idx_d = '0;
                if (mid && maj) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mid) begin
                    shift_d = {maj, shift_q[7:1]};
                end else if (last) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (mid) begin
                    par_bad_d = maj ^ (^shift_q);
                end else if (last) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Decide at mid-stop so a back-to-back start edge is not missed
                if (mid) begin
                    if (maj) begin
                        state_d = IDLE;
`ifdef UART_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rx_data_d   = shift_q;
                            rx_status_d = 1'b1;
                        end
`else
                        rx_data_d   = shift_q;
                        rx_status_d = 1'b1;
`endif
                    end else begin
                        state_d     = RECOVER;
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = RECOVER;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q     <= RECOVER;
            div_cnt_q   <= '0;
            tcnt_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            rx_data_q   <= 8'h00;
            rx_status_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            tcnt_q      <= tcnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            rx_data_q   <= rx_data_d;
            rx_status_q <= rx_status_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_status = rx_status_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule
